// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte-stream requesters, the TX FIFO write
// port and the arbiter. master = requesters/FIFO side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              setup_priority;

    logic              p0_valid;
    logic [DATA_W-1:0] p0_data;
    logic              p0_last;
    logic              p0_ready;
    logic              p0_overflow;

    logic              p1_valid;
    logic [DATA_W-1:0] p1_data;
    logic              p1_last;
    logic              p1_ready;
    logic              p1_overflow;

    logic              tx_full;
    logic              tx_wr_en;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        grant;
    logic              timeout_err;

    modport master (
        output setup_priority,
        output p0_valid, p0_data, p0_last,
        input  p0_ready, p0_overflow,
        output p1_valid, p1_data, p1_last,
        input  p1_ready, p1_overflow,
        output tx_full,
        input  tx_wr_en, tx_data, grant, timeout_err
    );

    modport slave (
        input  setup_priority,
        input  p0_valid, p0_data, p0_last,
        output p0_ready, p0_overflow,
        input  p1_valid, p1_data, p1_last,
        output p1_ready, p1_overflow,
        input  tx_full,
        output tx_wr_en, tx_data, grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked two-port arbiter feeding the UART TX FIFO write port, with
// round-robin between packets, setup-path priority and an idle watchdog.
module uart_tx_arbiter #(
    parameter int                   DATA_W       = 8,
    parameter int                   TMO_WIDTH    = 24,
    parameter logic [TMO_WIDTH-1:0] IDLE_TIMEOUT = 24'd2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = IDLE_TIMEOUT - 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               state;
    logic                 rr_ptr;
    logic [TMO_WIDTH-1:0] tmo_cnt;

    logic                 hold_vld0;
    logic [DATA_W-1:0]    hold_data0;
    logic                 hold_last0;
    logic                 hold_vld1;
    logic [DATA_W-1:0]    hold_data1;
    logic                 hold_last1;

    logic                 tx_wr_en_r;
    logic [DATA_W-1:0]    tx_data_r;
    logic [1:0]           grant_r;
    logic                 p0_ovf_r;
    logic                 p1_ovf_r;
    logic                 timeout_r;

    logic                 cur_vld;
    logic [DATA_W-1:0]    cur_data;
    logic                 cur_last;
    logic                 drain;
    logic                 drain0;
    logic                 drain1;

    // Hold register of whichever port currently owns the TX path
    always_comb begin
        cur_vld  = 1'b0;
        cur_data = '0;
        cur_last = 1'b0;
        if (state == GRANT0) begin
            cur_vld  = hold_vld0;
            cur_data = hold_data0;
            cur_last = hold_last0;
        end else if (state == GRANT1) begin
            cur_vld  = hold_vld1;
            cur_data = hold_data1;
            cur_last = hold_last1;
        end
    end

    assign drain  = cur_vld && !bus.tx_full;
    assign drain0 = drain && (state == GRANT0);
    assign drain1 = drain && (state == GRANT1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            tmo_cnt    <= '0;
            hold_vld0  <= 1'b0;
            hold_data0 <= '0;
            hold_last0 <= 1'b0;
            hold_vld1  <= 1'b0;
            hold_data1 <= '0;
            hold_last1 <= 1'b0;
            tx_wr_en_r <= 1'b0;
            tx_data_r  <= '0;
            grant_r    <= 2'b00;
            p0_ovf_r   <= 1'b0;
            p1_ovf_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            tx_wr_en_r <= 1'b0;
            timeout_r  <= 1'b0;
            p0_ovf_r   <= bus.p0_valid && hold_vld0;
            p1_ovf_r   <= bus.p1_valid && hold_vld1;

            // Ready is low while full, so a drain and a capture never collide
            if (drain0) begin
                hold_vld0 <= 1'b0;
            end else if (bus.p0_valid && !hold_vld0) begin
                hold_vld0  <= 1'b1;
                hold_data0 <= bus.p0_data;
                hold_last0 <= bus.p0_last;
            end

            if (drain1) begin
                hold_vld1 <= 1'b0;
            end else if (bus.p1_valid && !hold_vld1) begin
                hold_vld1  <= 1'b1;
                hold_data1 <= bus.p1_data;
                hold_last1 <= bus.p1_last;
            end

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (hold_vld0 && (bus.setup_priority || !hold_vld1 || !rr_ptr)) begin
                        state   <= GRANT0;
                        grant_r <= 2'b01;
                    end else if (hold_vld1) begin
                        state   <= GRANT1;
                        grant_r <= 2'b10;
                    end
                end

                GRANT0, GRANT1: begin
                    if (cur_vld) begin
                        // A full FIFO freezes both the byte and the watchdog
                        if (!bus.tx_full) begin
                            tx_wr_en_r <= 1'b1;
                            tx_data_r  <= cur_data;
                            tmo_cnt    <= '0;
                            if (cur_last) begin
                                state   <= IDLE;
                                grant_r <= 2'b00;
                                rr_ptr  <= (state == GRANT0);
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= IDLE;
                        grant_r   <= 2'b00;
                        rr_ptr    <= (state == GRANT0);
                        timeout_r <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    grant_r <= 2'b00;
                end
            endcase
        end
    end

    assign bus.p0_ready    = !hold_vld0;
    assign bus.p1_ready    = !hold_vld1;
    assign bus.p0_overflow = p0_ovf_r;
    assign bus.p1_overflow = p1_ovf_r;
    assign bus.tx_wr_en    = tx_wr_en_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.grant       = grant_r;
    assign bus.timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-port expected-byte queues are filled
// as bytes are driven and drained by a monitor as TX FIFO writes appear.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .DATA_W       (8),
        .TMO_WIDTH    (24),
        .IDLE_TIMEOUT (24'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         open_port = -1;
    logic [1:0] prev_grant = 2'b00;
    logic [8:0] mon_exp;
    int         mon_src;

    int w;
    int wr_cnt;
    int tmo_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int port);
        int n;
        n = 0;
        while (((port == 0) ? bus.p0_ready : bus.p1_ready) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", (n < 200), 1);
    endtask

    task automatic send(input int port, input logic [7:0] d, input logic l);
        wait_ready(port);
        if (port == 0) begin
            bus.p0_valid = 1'b1;
            bus.p0_data  = d;
            bus.p0_last  = l;
            q0.push_back({l, d});
        end else begin
            bus.p1_valid = 1'b1;
            bus.p1_data  = d;
            bus.p1_last  = l;
            q1.push_back({l, d});
        end
        @(negedge clk);
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
    endtask

    task automatic strobe2(input logic [7:0] d0, input logic l0, input logic [7:0] d1, input logic l1);
        bus.p0_valid = 1'b1;
        bus.p0_data  = d0;
        bus.p0_last  = l0;
        bus.p1_valid = 1'b1;
        bus.p1_data  = d1;
        bus.p1_last  = l1;
        q0.push_back({l0, d0});
        q1.push_back({l1, d1});
        @(negedge clk);
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && bus.grant === 2'b00) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_bound"}, (n < 300), 1);
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        while (bus.tx_wr_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wr_seen"}, bus.tx_wr_en, 1);
    endtask

    // Scoreboard: every write must come from the previous-cycle owner, match
    // that port's next expected byte, and never split another open packet.
    always @(negedge clk) begin
        if (bus.timeout_err === 1'b1) open_port = -1;
        if (bus.tx_wr_en === 1'b1) begin
            check("wr_owner", (prev_grant == 2'b01) || (prev_grant == 2'b10), 1);
            mon_src = (prev_grant == 2'b10) ? 1 : 0;
            check("wr_pkt_lock", (open_port < 0) || (open_port == mon_src), 1);
            if (mon_src == 0) begin
                check("wr_pending_p0", (q0.size() != 0), 1);
                mon_exp = (q0.size() != 0) ? q0.pop_front() : 9'h000;
            end else begin
                check("wr_pending_p1", (q1.size() != 0), 1);
                mon_exp = (q1.size() != 0) ? q1.pop_front() : 9'h000;
            end
            check("wr_data", bus.tx_data, mon_exp[7:0]);
            open_port = mon_exp[8] ? -1 : mon_src;
        end
        prev_grant = bus.grant;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit reached");
    end

    initial begin
        rst_n              = 1'b0;
        bus.setup_priority = 1'b0;
        bus.p0_valid       = 1'b0;
        bus.p0_data        = 8'h00;
        bus.p0_last        = 1'b0;
        bus.p1_valid       = 1'b0;
        bus.p1_data        = 8'h00;
        bus.p1_last        = 1'b0;
        bus.tx_full        = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_wr_en", bus.tx_wr_en, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_p0_overflow", bus.p0_overflow, 0);
        check("rst_p1_overflow", bus.p1_overflow, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_ready", {bus.p0_ready, bus.p1_ready}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);

        // "AT\r\n" on the setup path
        send(0, 8'h41, 1'b0);
        check("t1_idle_while_hold", bus.grant, 2'b00);
        check("t1_p0_ready_low", bus.p0_ready, 0);
        @(negedge clk);
        check("t1_grant_n2", bus.grant, 2'b01);
        check("t1_no_wr_n2", bus.tx_wr_en, 0);
        @(negedge clk);
        check("t1_first_wr_n3", bus.tx_wr_en, 1);
        send(0, 8'h54, 1'b0);
        @(negedge clk);
        check("t1_inpkt_wr_n2", bus.tx_wr_en, 1);
        send(0, 8'h0D, 1'b0);
        send(0, 8'h0A, 1'b1);
        wait_idle("t1");

        // Simultaneous loads: rr_ptr=1 picks port 1
        strobe2(8'hA0, 1'b0, 8'hB0, 1'b0);
        @(negedge clk);
        check("t2a_rr1_winner", bus.grant, 2'b10);
        send(1, 8'hB1, 1'b1);
        send(0, 8'hA1, 1'b1);
        wait_idle("t2a");

        // Bring rr_ptr to 0, then port 0 must win
        send(1, 8'hB2, 1'b1);
        wait_idle("t2b_pre");
        strobe2(8'hA2, 1'b0, 8'hB3, 1'b0);
        @(negedge clk);
        check("t2b_rr0_winner", bus.grant, 2'b01);
        send(0, 8'hA3, 1'b1);
        send(1, 8'hB4, 1'b1);
        wait_idle("t2b");

        // Bring rr_ptr to 1, setup_priority overrides it
        send(0, 8'hA4, 1'b1);
        wait_idle("t2c_pre");
        bus.setup_priority = 1'b1;
        strobe2(8'hA5, 1'b1, 8'hB5, 1'b1);
        @(negedge clk);
        check("t2c_prio_winner", bus.grant, 2'b01);
        wait_idle("t2c");
        bus.setup_priority = 1'b0;

        // Port 1 mid-packet keeps the grant; port 0 holds one byte, overflows the next
        send(1, 8'h31, 1'b0);
        @(negedge clk);
        check("t3_p1_granted", bus.grant, 2'b10);
        wait_write("t3");
        send(0, 8'h41, 1'b1);
        bus.p0_valid = 1'b1;
        bus.p0_data  = 8'h42;
        bus.p0_last  = 1'b1;
        @(negedge clk);
        bus.p0_valid = 1'b0;
        check("t3_p0_overflow", bus.p0_overflow, 1);
        check("t3_keep_grant", bus.grant, 2'b10);
        @(negedge clk);
        check("t3_overflow_pulse", bus.p0_overflow, 0);
        send(1, 8'h32, 1'b0);
        send(1, 8'h33, 1'b1);
        wait_idle("t3");

        // FIFO full stall: no write, no watchdog, single write on release
        bus.tx_full = 1'b1;
        send(0, 8'h55, 1'b1);
        @(negedge clk);
        check("t4_grant", bus.grant, 2'b01);
        wr_cnt   = 0;
        tmo_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx_wr_en === 1'b1) wr_cnt++;
            if (bus.timeout_err === 1'b1) tmo_seen++;
        end
        check("t4_stall_no_wr", wr_cnt, 0);
        check("t4_stall_no_timeout", tmo_seen, 0);
        bus.tx_full = 1'b0;
        @(negedge clk);
        check("t4_release_wr", bus.tx_wr_en, 1);
        wr_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx_wr_en === 1'b1) wr_cnt++;
        end
        check("t4_written_once", wr_cnt, 0);
        check("t4_back_idle", bus.grant, 2'b00);

        // Watchdog: port 1 stalls after one non-last byte, port 0 waits
        send(1, 8'h61, 1'b0);
        wait_write("t5");
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) begin
                bus.p0_valid = 1'b1;
                bus.p0_data  = 8'h71;
                bus.p0_last  = 1'b1;
                q0.push_back({1'b1, 8'h71});
            end
            @(negedge clk);
            bus.p0_valid = 1'b0;
            if (i == 15) check("t5_no_early_timeout", bus.timeout_err, 0);
        end
        check("t5_timeout_pulse", bus.timeout_err, 1);
        check("t5_grant_revoked", bus.grant, 2'b00);
        @(negedge clk);
        check("t5_p0_granted", bus.grant, 2'b01);
        check("t5_timeout_once", bus.timeout_err, 0);
        wait_idle("t5");

        // Reset mid-packet with both holds full discards everything
        send(1, 8'h81, 1'b0);
        wait_write("t6");
        bus.tx_full  = 1'b1;
        bus.p0_valid = 1'b1;
        bus.p0_data  = 8'h91;
        bus.p0_last  = 1'b0;
        bus.p1_valid = 1'b1;
        bus.p1_data  = 8'h82;
        bus.p1_last  = 1'b1;
        @(negedge clk);
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        check("t6_holds_full", {bus.p0_ready, bus.p1_ready}, 2'b00);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_tx_wr_en", bus.tx_wr_en, 0);
        check("t6_rst_tx_data", bus.tx_data, 8'h00);
        check("t6_rst_grant", bus.grant, 2'b00);
        check("t6_rst_ready", {bus.p0_ready, bus.p1_ready}, 2'b11);
        check("t6_rst_timeout_err", bus.timeout_err, 0);
        rst_n       = 1'b1;
        bus.tx_full = 1'b0;
        open_port   = -1;
        wr_cnt      = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_wr_en === 1'b1) wr_cnt++;
        end
        check("t6_no_wr_after_rst", wr_cnt, 0);
        check("t6_grant_stays_idle", bus.grant, 2'b00);

        check("end_q0_drained", q0.size(), 0);
        check("end_q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART TX FIFO write port between two byte-stream requesters. Port 0 is the BLE AT-command path (setup flow). Port 1 is the application data stream. Grants are packet-locked: once a port is granted, it keeps the TX path until its last byte is forwarded or an idle watchdog expires. Round-robin fairness applies between packets, and a priority override lets the setup flow pre-empt at packet boundaries.

Parameters:
TMO_WIDTH, 24, width of idle-watchdog counter.
IDLE_TIMEOUT, 24'd2_000_000, clk cycles a granted port may stay without a pending byte before its grant is revoked.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
setup_priority  input  1  when high, port 0 wins every arbitration in IDLE
p0_valid  input  1  single-cycle byte strobe, port 0
p0_data  input  8  byte, port 0
p0_last  input  1  byte is end of packet, port 0 (command path drives 1 with 8'h0A)
p0_ready  output  1  combinational, = !hold_vld0
p0_overflow  output  1  1-cycle pulse: p0_valid seen while hold full, byte dropped
p1_valid / p1_data / p1_last / p1_ready / p1_overflow  same as port 0, for port 1
tx_full  input  1  TX FIFO full, write must not occur
tx_wr_en  output  1  registered 1-cycle write strobe to TX FIFO
tx_data  output  8  registered byte to TX FIFO, valid with tx_wr_en
grant  output  2  one-hot current owner (bit i = port i), 2'b00 in IDLE
timeout_err  output  1  1-cycle pulse on watchdog revocation

Behaviour:
- Reset, sampled on clk with rst_n=0: state=IDLE, rr_ptr=0, hold_vld0/1=0, hold data/last=0, tmo_cnt=0. Outputs tx_wr_en=0, tx_data=8'h00, grant=2'b00, p*_overflow=0, timeout_err=0. Reset mid-packet discards held bytes and any partial packet without emitting a write.
- Per-port 1-entry hold register. When pi_valid && !hold_vldi, it captures data and last, and hold_vldi=1 the next cycle. When pi_valid && hold_vldi, the input is not captured and pi_overflow pulses the next cycle. A drain clears hold_vldi the next cycle. Capture and drain never coincide because ready is low while the register is full.
- States:
  - IDLE: arbitration only; no writes.
  - GRANT0 and GRANT1: forward only the granted port's held bytes.
- IDLE transitions:
  - If setup_priority && hold_vld0, go to GRANT0.
  - Otherwise, if exactly one hold_vld is set, go to that port.
  - If both are set, go to the port equal to rr_ptr.
  - If none is set, stay in IDLE.
- GRANTi drain: if hold_vldi && !tx_full, then next cycle tx_wr_en=1, tx_data=held byte, hold cleared, tmo_cnt=0. If the held last=1, the next state is IDLE and rr_ptr=~i. If tx_full=1, nothing is written and the byte stays held; stall cycles do not advance the watchdog.
- Watchdog, GRANTi with hold_vldi=0: tmo_cnt increments each cycle. When tmo_cnt==IDLE_TIMEOUT-1, the next state is IDLE, timeout_err pulses, rr_ptr=~i and tmo_cnt=0. tmo_cnt is cleared in IDLE and on every drain. It never wraps because it is compared before incrementing.
- The non-granted port may still capture one byte into its hold register. Further strobes from that port overflow until it is granted.
- Latency:
  - Packet start from IDLE: pi_valid at cycle N, hold at N+1, GRANTi at N+2, tx_wr_en at N+3.
  - Within a packet: pi_valid at N, tx_wr_en at N+2.
  - Back-to-back packets: IDLE lasts one cycle between the last write of one packet and the grant for the next.
- setup_priority changing mid-packet has no effect until the next IDLE.
- grant is the registered one-hot of the state.
- At most one tx_wr_en per cycle.

Test Plan:
- Port 0 sends "AT\r\n" (last on 8'h0A), port 1 idle, tx_full=0 -> grant=01 from N+2. tx_wr_en carries 41,54,0D,0A in order, first write at N+3. Returns to IDLE with rr_ptr=1.
- Both ports load first bytes in the same cycle, rr_ptr=0, setup_priority=0 -> port 0 packet is fully sent first, then port 1 packet. With setup_priority=1 and rr_ptr=1, port 0 still wins.
- Port 1 mid-packet, port 0 loads 8'h41 -> port 1 keeps grant through its last byte. Port 0's second strobe gives p0_overflow=1. Port 0 is then granted and 8'h41 is written.
- Granted port 0 holds 8'h55 with tx_full=1 for 50 cycles -> no tx_wr_en and no timeout. After tx_full falls, 8'h55 is written exactly once.
- IDLE_TIMEOUT=16, port 1 sends one non-last byte then stops -> timeout_err pulses 16 cycles after the drain, grant=00, and a pending port 0 byte is granted next.
- rst_n=0 for one cycle mid-packet with both holds full -> all outputs return to reset values and no write of held bytes follows.
